// File: rtl/rom_spi_write_responder_pkg.sv
// Shared types and constants for the ROM SPI write responder.
// Holds the FSM encoding, SRAM opcodes and frame sizing helpers.
package rom_spi_pkg;

    typedef enum logic [2:0] {
        INIT_SHIFT,
        INIT_GAP,
        IDLE,
        WR_SHIFT,
        WR_GAP
    } state_t;

    localparam logic [7:0] CMD_WRITE_DEF = 8'h02;
    localparam logic [7:0] CMD_WRMR_DEF  = 8'h01;
    localparam logic [7:0] MODE_SEQ_DEF  = 8'h40;

    localparam int SRAM_ADDR_BYTES = 3;
    localparam int SHIFT_MAX       = 64;
    localparam int CNT_W           = 7;

    function automatic int wr_bits(input int data_width);
        return 8 + 8 * SRAM_ADDR_BYTES + data_width;
    endfunction

endpackage

// File: rtl/rom_spi_write_responder_spi_shift_tx.sv
// SPI mode-0 transmitter at clk/2: MSB-first from a left-aligned word.
// Owns the sclk phase toggle and the remaining-bit counter.
module spi_shift_tx
    import rom_spi_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [SHIFT_MAX-1:0] word,
    input  logic [CNT_W-1:0]     bits,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 done
);

    logic [SHIFT_MAX-1:0] shreg_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 phase_q;
    logic                 active_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q  <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            active_q <= 1'b0;
        end else if (load) begin
            shreg_q  <= word;
            cnt_q    <= bits;
            phase_q  <= 1'b0;
            active_q <= (bits != '0);
        end else if (active_q) begin
            phase_q <= ~phase_q;
            // Advance only after the SRAM has seen the rising edge
            if (phase_q) begin
                shreg_q <= shreg_q << 1;
                cnt_q   <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    active_q <= 1'b0;
            end
        end
    end

    assign sclk = active_q & phase_q;
    assign mosi = shreg_q[SHIFT_MAX-1];
    assign done = active_q & phase_q & (cnt_q == CNT_W'(1));

endmodule

// File: rtl/rom_spi_write_responder.sv
// Loader-facing write responder: inits SPI SRAM mode, then
// turns each accepted rom_request into one SPI WRITE frame.
module rom_spi_write_responder
    import rom_spi_pkg::*;
#(
    parameter int         DATA_WIDTH    = 16,
    parameter int         ADDRESS_WIDTH = 16,
    parameter logic [7:0] CMD_WRITE     = CMD_WRITE_DEF,
    parameter logic [7:0] CMD_WRMR      = CMD_WRMR_DEF,
    parameter logic [7:0] MODE_SEQ      = MODE_SEQ_DEF,
    parameter int         CS_GAP        = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rom_request,
    input  logic [DATA_WIDTH-1:0]    rom_data,
    input  logic [ADDRESS_WIDTH-1:0] rom_address,
    output logic                     rom_busy,
    output logic                     rom_initialized,
    output logic                     spi_cs_n,
    output logic                     spi_sclk,
    output logic                     spi_mosi
);

    localparam int WR_BITS   = wr_bits(DATA_WIDTH);
    localparam int INIT_BITS = 16;
    localparam int ADDR_BITS = 8 * SRAM_ADDR_BYTES;
    localparam int GAP_W     = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                init_q, init_d;
    logic                cs_n_q, cs_n_d;
    logic                pend_q, pend_d;
    logic [GAP_W-1:0]    gap_q, gap_d;

    logic                 tx_load;
    logic [SHIFT_MAX-1:0] tx_word;
    logic [CNT_W-1:0]     tx_bits;
    logic                 tx_done;

    logic [ADDR_BITS-1:0] byte_addr;
    logic [WR_BITS-1:0]   wr_raw;
    logic [SHIFT_MAX-1:0] wr_word;
    logic [SHIFT_MAX-1:0] init_word;

    assign byte_addr = ADDR_BITS'({rom_address, 1'b0});
    assign wr_raw    = {CMD_WRITE, byte_addr, rom_data};
    assign wr_word   = SHIFT_MAX'(wr_raw) << (SHIFT_MAX - WR_BITS);
    assign init_word = SHIFT_MAX'({CMD_WRMR, MODE_SEQ})
                       << (SHIFT_MAX - INIT_BITS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= INIT_SHIFT;
            busy_q  <= 1'b1;
            init_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            pend_q  <= 1'b1;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            init_q  <= init_d;
            cs_n_q  <= cs_n_d;
            pend_q  <= pend_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        init_d  = init_q;
        cs_n_d  = cs_n_q;
        pend_d  = pend_q;
        gap_d   = gap_q;
        tx_load = 1'b0;
        tx_word = '0;
        tx_bits = '0;
        unique case (state_q)
            INIT_SHIFT: begin
                // Mode-register frame starts on the first edge out of reset
                if (pend_q) begin
                    tx_load = 1'b1;
                    tx_word = init_word;
                    tx_bits = CNT_W'(INIT_BITS);
                    cs_n_d  = 1'b0;
                    pend_d  = 1'b0;
                end else if (tx_done) begin
                    state_d = INIT_GAP;
                    cs_n_d  = 1'b1;
                    gap_d   = GAP_W'(CS_GAP - 1);
                end
            end
            INIT_GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                    init_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            IDLE: begin
                if (rom_request && !busy_q) begin
                    tx_load = 1'b1;
                    tx_word = wr_word;
                    tx_bits = CNT_W'(WR_BITS);
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    state_d = WR_SHIFT;
                end
            end
            WR_SHIFT: begin
                if (tx_done) begin
                    state_d = WR_GAP;
                    cs_n_d  = 1'b1;
                    gap_d   = GAP_W'(CS_GAP - 1);
                end
            end
            WR_GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = INIT_SHIFT;
        endcase
    end

    spi_shift_tx u_tx (
        .clk   (clk),
        .reset (reset),
        .load  (tx_load),
        .word  (tx_word),
        .bits  (tx_bits),
        .sclk  (spi_sclk),
        .mosi  (spi_mosi),
        .done  (tx_done)
    );

    assign rom_busy        = busy_q;
    assign rom_initialized = init_q;
    assign spi_cs_n        = cs_n_q;

endmodule

// File: doc/rom_spi_write_responder.md
Name: rom_spi_write_responder

Overview:
- Responder end of the ROM write handshake (rom_request / rom_busy / rom_initialized) driven by the stream loader.
- After reset it initialises an external SPI SRAM: one WRMR command selecting sequential mode, then rom_initialized rises.
- Each accepted request is latched and serialised as an SPI WRITE (command, 24-bit byte address, data word), with rom_busy held for the whole transaction.
- Sits between the loader and the SPI SRAM pins holding the Hack ROM image.

Parameters:
DATA_WIDTH, 16, data word width in bits; must be a multiple of 8.
ADDRESS_WIDTH, 16, word address width; must be 23 or less.
CMD_WRITE, 8'h02, SRAM write opcode.
CMD_WRMR, 8'h01, SRAM write-mode-register opcode.
MODE_SEQ, 8'h40, mode register value (sequential mode).
CS_GAP, 2, clk cycles spi_cs_n is held high after every transaction; minimum 1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rom_request  in  1  write request from the loader
rom_data  in  DATA_WIDTH  word to write, sampled at acceptance
rom_address  in  ADDRESS_WIDTH  word address, sampled at acceptance
rom_busy  out  1  high while initialising or writing
rom_initialized  out  1  high once the mode register has been written; stays high until reset
spi_cs_n  out  1  SRAM chip select, active low
spi_sclk  out  1  SPI clock, mode 0, clk/2
spi_mosi  out  1  serial data, MSB first

Behaviour:
- Reset asserted (reset=0), asynchronously:
  - state=INIT_SHIFT armed; rom_busy=1, rom_initialized=0.
  - spi_cs_n=1, spi_sclk=0, spi_mosi=0; shift register and bit counter cleared.
- First clk edge after reset deasserts: load {CMD_WRMR, MODE_SEQ} into the shifter and drive spi_cs_n=0.
- States: INIT_SHIFT, INIT_GAP, IDLE, WR_SHIFT, WR_GAP.
- Shift timing, 2 clk per bit:
  - Phase 0: spi_sclk=0, spi_mosi=current MSB.
  - Phase 1: spi_sclk=1, so the SRAM samples on the rising edge.
  - At the end of phase 1 the shifter moves left by one and the bit counter decrements.
  - spi_cs_n stays low for the entire SHIFT state.
- INIT_SHIFT: 16 bits = 32 cycles, then INIT_GAP.
- INIT_GAP: spi_cs_n=1, spi_sclk=0 for CS_GAP cycles. On exit: rom_initialized=1, rom_busy=0, go to IDLE.
- IDLE:
  - Accept condition: rom_request=1 and rom_busy=0 at a clk edge.
  - On acceptance, at the same edge: latch the shifter with {CMD_WRITE, byte_addr, rom_data}, set rom_busy=1, spi_cs_n=0, go to WR_SHIFT.
  - byte_addr is 24 bits = zero-extended {rom_address, 1'b0}, i.e. word address times 2.
- WR_SHIFT: 32+DATA_WIDTH bits (48 for the default), 2*(32+DATA_WIDTH) cycles, then WR_GAP.
- WR_GAP: spi_cs_n=1 for CS_GAP cycles; on exit rom_busy=0, go to IDLE.
- rom_busy latency and duration:
  - rom_busy is visible the cycle after acceptance.
  - For the default parameters it stays high for exactly 96+CS_GAP = 98 cycles.
  - The loader drops rom_request on seeing busy and waits for its fall; that fall is the completion acknowledge.
- rom_request while rom_busy=1 (INIT or WR states) is ignored: no latch, no queueing.
- rom_request held continuously through the end of WR_GAP: the next acceptance can occur no earlier than the first IDLE cycle, so busy shows at least one low cycle between writes.
- rom_data and rom_address are don't-care outside the acceptance edge.
- Reset mid-transaction: spi_cs_n goes high immediately (the SRAM aborts the write) and the block re-runs initialisation. The interrupted write is lost.
- Address wrap: rom_address all-ones maps to byte address (2^(ADDRESS_WIDTH+1))-2; there is no overflow handling.

Decomposition:
- Package rom_spi_pkg holds:
  - state encoding enum (5 states);
  - CMD_WRITE, CMD_WRMR, MODE_SEQ defaults;
  - SRAM_ADDR_BYTES=3;
  - the WR_BITS = 8 + 24 + DATA_WIDTH helper.
- One sub-module, spi_shift_tx:
  - inputs: load strobe, parallel word up to 64 bits, bit count;
  - outputs: sclk, mosi, done pulse.
  - Owns the phase toggle and bit counter.
- The top level holds the FSM, the handshake and chip-select/gap timing.

Test Plan:
- Reset release -> spi_cs_n low for 32 cycles; MOSI sampled on sclk rising edges = 0x0140; then spi_cs_n high for 2 cycles; then rom_initialized=1, rom_busy=0.
- rom_request=1, address=0x0003, data=0xBEEF in IDLE -> rom_busy=1 the next cycle; MOSI stream 0x02_000006_BEEF over 96 cycles; rom_busy falls 98 cycles after acceptance.
- rom_request pulsed during the init phase and again mid-write -> no extra transaction starts, spi_cs_n edge count unchanged, and the latched data stays 0xBEEF.
- Drive with the real stream loader for 8 words -> captured SRAM model contents match at byte addresses 0x00..0x0E, and the loader address ends at 8.
- reset=0 asserted at cycle 40 of a write -> spi_cs_n=1 asynchronously (same cycle); after release the init sequence 0x0140 repeats and rom_initialized stays 0 until it completes.
- address=0xFFFF, data=0x0001 -> byte address 0x01FFFE is shifted, with no corruption of the command or data fields.
